// File: rtl/wb_ext_guard.sv
// wb_ext_guard: registered Wishbone B3 bridge between a compute tile's external
// memory master port and the Wishbone-to-AXI DDR converter. Every upstream beat
// (classic or burst) is replayed downstream as an independent classic cycle, and
// all outputs come from flops so no combinational path crosses the bridge.
//
// Optional watchdog: define WB_EXT_GUARD_TIMEOUT_EN to abort a downstream access
// that has not answered within TIMEOUT cycles. It ends with an upstream err and a
// one-cycle timeout_o pulse. Without the macro the counter is absent, an access
// waits indefinitely and timeout_o is tied low.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   s_wb_*                upstream slave port (tile side); cti/bte only delimit beats
//   m_wb_*                downstream master port (DDR converter side), classic only
//   timeout_o             one-cycle pulse when the watchdog aborts an access
//
// state   | meaning
// IDLE    | waiting for an upstream cyc & stb; captures the request
// ACCESS  | downstream cycle in flight; waits for ack/err/rty (or watchdog)
// RESPOND | one-cycle upstream termination; request fields may change here

module wb_ext_guard #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                    s_wb_we_i,
  input  logic                    s_wb_cyc_i,
  input  logic                    s_wb_stb_i,
  input  logic [2:0]              s_wb_cti_i,
  input  logic [1:0]              s_wb_bte_i,
  output logic                    s_wb_ack_o,
  output logic                    s_wb_err_o,
  output logic                    s_wb_rty_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic [ADDR_WIDTH-1:0]   m_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   m_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] m_wb_sel_o,
  output logic                    m_wb_we_o,
  output logic                    m_wb_cyc_o,
  output logic                    m_wb_stb_o,
  output logic [2:0]              m_wb_cti_o,
  output logic [1:0]              m_wb_bte_o,
  input  logic                    m_wb_ack_i,
  input  logic                    m_wb_err_i,
  input  logic                    m_wb_rty_i,
  input  logic [DATA_WIDTH-1:0]   m_wb_dat_i,
  output logic                    timeout_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t state;
  logic   resp;

  // Burst tags only tell the tile where beats start and end; each beat is
  // handled as a classic cycle, so the tags themselves are not needed.
  logic unused_burst_tags;
  assign unused_burst_tags = ^{s_wb_cti_i, s_wb_bte_i};

  assign m_wb_cti_o = 3'b000;
  assign m_wb_bte_o = 2'b00;
  assign resp       = m_wb_ack_i | m_wb_err_i | m_wb_rty_i;

`ifdef WB_EXT_GUARD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign expire = (cnt == CNT_W'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;

  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m_wb_adr_o <= '0;
      m_wb_dat_o <= '0;
      m_wb_sel_o <= '0;
      m_wb_we_o  <= 1'b0;
      m_wb_cyc_o <= 1'b0;
      m_wb_stb_o <= 1'b0;
      s_wb_ack_o <= 1'b0;
      s_wb_err_o <= 1'b0;
      s_wb_rty_o <= 1'b0;
      s_wb_dat_o <= '0;
`ifdef WB_EXT_GUARD_TIMEOUT_EN
      cnt        <= '0;
      timeout_o  <= 1'b0;
`endif
    end else begin
`ifdef WB_EXT_GUARD_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (s_wb_cyc_i && s_wb_stb_i) begin
            m_wb_adr_o <= s_wb_adr_i;
            m_wb_dat_o <= s_wb_dat_i;
            m_wb_sel_o <= s_wb_sel_i;
            m_wb_we_o  <= s_wb_we_i;
            m_wb_cyc_o <= 1'b1;
            m_wb_stb_o <= 1'b1;
`ifdef WB_EXT_GUARD_TIMEOUT_EN
            cnt        <= '0;
`endif
            state      <= ACCESS;
          end
        end

        ACCESS: begin
          // A response in the watchdog's last cycle still wins.
          if (resp) begin
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            // The upstream cyc gate drops the answer if the tile abandoned the cycle.
            s_wb_err_o <= m_wb_err_i & s_wb_cyc_i;
            s_wb_rty_o <= ~m_wb_err_i & m_wb_rty_i & s_wb_cyc_i;
            s_wb_ack_o <= ~m_wb_err_i & ~m_wb_rty_i & s_wb_cyc_i;
            s_wb_dat_o <= (!m_wb_err_i && !m_wb_rty_i && !m_wb_we_o) ? m_wb_dat_i : '0;
            state      <= RESPOND;
          end
`ifdef WB_EXT_GUARD_TIMEOUT_EN
          else if (expire) begin
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            s_wb_err_o <= s_wb_cyc_i;
            s_wb_dat_o <= '0;
            timeout_o  <= 1'b1;
            state      <= RESPOND;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end

        RESPOND: begin
          // The tile updates its request during this cycle, so IDLE must not
          // see the acknowledged beat again.
          s_wb_ack_o <= 1'b0;
          s_wb_err_o <= 1'b0;
          s_wb_rty_o <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ext_guard.sv
// Testbench for wb_ext_guard: directed scenarios followed by randomized beats,
// checked against a transaction-level reference of the bridge's behaviour.
module tb_wb_ext_guard;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s_wb_adr_i;
  logic [DW-1:0] s_wb_dat_i;
  logic [SW-1:0] s_wb_sel_i;
  logic          s_wb_we_i, s_wb_cyc_i, s_wb_stb_i;
  logic [2:0]    s_wb_cti_i;
  logic [1:0]    s_wb_bte_i;
  logic          s_wb_ack_o, s_wb_err_o, s_wb_rty_o;
  logic [DW-1:0] s_wb_dat_o;
  logic [AW-1:0] m_wb_adr_o;
  logic [DW-1:0] m_wb_dat_o;
  logic [SW-1:0] m_wb_sel_o;
  logic          m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
  logic [2:0]    m_wb_cti_o;
  logic [1:0]    m_wb_bte_o;
  logic          m_wb_ack_i, m_wb_err_i, m_wb_rty_i;
  logic [DW-1:0] m_wb_dat_i;
  logic          timeout_o;

  int vectors     = 0;
  int miscompares = 0;
  bit after_resp  = 1'b0;

  always #5 clk = ~clk;

  wb_ext_guard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_sel_i(s_wb_sel_i),
    .s_wb_we_i(s_wb_we_i), .s_wb_cyc_i(s_wb_cyc_i), .s_wb_stb_i(s_wb_stb_i),
    .s_wb_cti_i(s_wb_cti_i), .s_wb_bte_i(s_wb_bte_i),
    .s_wb_ack_o(s_wb_ack_o), .s_wb_err_o(s_wb_err_o), .s_wb_rty_o(s_wb_rty_o),
    .s_wb_dat_o(s_wb_dat_o),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_sel_o(m_wb_sel_o),
    .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
    .m_wb_cti_o(m_wb_cti_o), .m_wb_bte_o(m_wb_bte_o),
    .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i), .m_wb_rty_i(m_wb_rty_i),
    .m_wb_dat_i(m_wb_dat_i),
    .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Upstream termination as {err, rty, ack}.
  function automatic logic [2:0] term_now();
    return {s_wb_err_o, s_wb_rty_o, s_wb_ack_o};
  endfunction

  // Reference: downstream kinds {err, rty, ack}; err beats rty beats ack.
  function automatic logic [2:0] model_term(input logic [2:0] kinds);
    if (kinds[2])      return 3'b100;
    else if (kinds[1]) return 3'b010;
    else               return 3'b001;
  endfunction

  task automatic idle(input int n);
    s_wb_cyc_i = 1'b0;
    s_wb_stb_i = 1'b0;
    repeat (n) @(negedge clk);
    after_resp = 1'b0;
  endtask

  // One upstream beat with a downstream slave that answers after wait_n cycles.
  // Called at a negedge; returns at the negedge of the RESPOND cycle.
  task automatic xfer(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [SW-1:0] sel, input logic we, input int wait_n,
                      input logic [2:0] kinds, input logic [DW-1:0] rdat,
                      input logic [2:0] cti, input logic last);
    logic [2:0]    exp_term;
    logic [DW-1:0] exp_dat;
    s_wb_adr_i = adr;
    s_wb_dat_i = dat;
    s_wb_sel_i = sel;
    s_wb_we_i  = we;
    s_wb_cti_i = cti;
    s_wb_cyc_i = 1'b1;
    s_wb_stb_i = 1'b1;
    if (after_resp) begin
      @(negedge clk);
      check("gap_m_cyc", 64'(m_wb_cyc_o), 64'd0);
      check("gap_s_term", 64'(term_now()), 64'd0);
    end
    @(negedge clk);
    check("acc_cyc_stb", 64'({m_wb_cyc_o, m_wb_stb_o}), 64'b11);
    check("acc_adr", 64'(m_wb_adr_o), 64'(adr));
    check("acc_dat", 64'(m_wb_dat_o), 64'(dat));
    check("acc_sel_we", 64'({m_wb_sel_o, m_wb_we_o}), 64'({sel, we}));
    check("acc_cti_bte", 64'({m_wb_cti_o, m_wb_bte_o}), 64'd0);
    check("acc_s_term", 64'(term_now()), 64'd0);
    for (int i = 0; i < wait_n; i++) begin
      m_wb_dat_i = $urandom;
      @(negedge clk);
      check("wait_stb", 64'({m_wb_stb_o, term_now()}), 64'b1000);
    end
    {m_wb_err_i, m_wb_rty_i, m_wb_ack_i} = kinds;
    m_wb_dat_i = rdat;
    @(negedge clk);
    {m_wb_err_i, m_wb_rty_i, m_wb_ack_i} = 3'b000;
    m_wb_dat_i = $urandom;
    exp_term = model_term(kinds);
    exp_dat  = (exp_term == 3'b001 && !we) ? rdat : '0;
    check("resp_term", 64'(term_now()), 64'(exp_term));
    check("resp_dat", 64'(s_wb_dat_o), 64'(exp_dat));
    check("resp_m_cyc_to", 64'({m_wb_cyc_o, m_wb_stb_o, timeout_o}), 64'd0);
    if (last) begin
      s_wb_cyc_i = 1'b0;
      s_wb_stb_i = 1'b0;
    end
    after_resp = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] r_adr;
    logic [2:0]    r_kinds;
    logic          r_last;

    rst = 1'b1;
    s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_sel_i = '0; s_wb_we_i = 1'b0;
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0; s_wb_cti_i = 3'b000; s_wb_bte_i = 2'b00;
    m_wb_ack_i = 1'b0; m_wb_err_i = 1'b0; m_wb_rty_i = 1'b0; m_wb_dat_i = '0;

    repeat (2) @(negedge clk);
    check("rst_m_req", 64'({m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_sel_o}), 64'd0);
    check("rst_m_adr_dat", 64'({m_wb_adr_o, m_wb_dat_o}), 64'd0);
    check("rst_s_term", 64'({term_now(), timeout_o}), 64'd0);
    check("rst_s_dat", 64'(s_wb_dat_o), 64'd0);
    rst = 1'b0;

    // Single write with zero-wait downstream.
    xfer(28'h0000100, 32'hCAFEF00D, 4'hF, 1'b1, 0, 3'b001, 32'h0, 3'b000, 1'b1);
    // Single read, five wait states.
    xfer(28'h0000204, 32'h0, 4'hF, 1'b0, 5, 3'b001, 32'h12345678, 3'b000, 1'b1);
    idle(2);
    check("idle_dat_held", 64'(s_wb_dat_o), 64'h12345678);

    // Four-beat incrementing burst.
    for (int b = 0; b < 4; b++)
      xfer(28'h40 + 28'(b * 4), 32'h1000 + 32'(b), 4'hF, 1'b0, b % 2, 3'b001,
           32'hB0B0_0000 + 32'(b), (b == 3) ? 3'b111 : 3'b010, b == 3);

    // Combined downstream terminations.
    xfer(28'h500, 32'h0, 4'h3, 1'b0, 1, 3'b101, 32'hDEAD0001, 3'b000, 1'b1);
    check("err_ack_dat", 64'(s_wb_dat_o), 64'd0);
    xfer(28'h504, 32'h0, 4'hC, 1'b0, 0, 3'b011, 32'hDEAD0002, 3'b000, 1'b1);

    // Response on the watchdog's last counted cycle is honoured.
    xfer(28'h600, 32'h0, 4'hF, 1'b0, TO - 1, 3'b001, 32'h0BADBEEF, 3'b000, 1'b1);

    // Downstream never answers.
    idle(1);
    s_wb_adr_i = 28'h700; s_wb_we_i = 1'b0; s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1;
`ifdef WB_EXT_GUARD_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      check("wd_wait", 64'({m_wb_cyc_o, term_now(), timeout_o}), 64'b10000);
    end
    @(negedge clk);
    check("wd_fire", 64'({m_wb_cyc_o, term_now(), timeout_o}), 64'b01001);
    check("wd_dat", 64'(s_wb_dat_o), 64'd0);
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0;
    m_wb_ack_i = 1'b1;
    @(negedge clk);
    check("wd_after", 64'({m_wb_cyc_o, term_now(), timeout_o}), 64'd0);
    @(negedge clk);
    check("wd_late_ack", 64'({m_wb_cyc_o, term_now(), timeout_o}), 64'd0);
    m_wb_ack_i = 1'b0;
    after_resp = 1'b0;
`else
    repeat (3 * TO) @(negedge clk);
    check("nowd_wait", 64'({m_wb_cyc_o, m_wb_stb_o, term_now(), timeout_o}), 64'b110000);
    m_wb_ack_i = 1'b1; m_wb_dat_i = 32'h5A5A5A5A;
    @(negedge clk);
    m_wb_ack_i = 1'b0;
    check("nowd_resp", 64'({m_wb_cyc_o, term_now(), timeout_o}), 64'b00010);
    check("nowd_dat", 64'(s_wb_dat_o), 64'h5A5A5A5A);
    after_resp = 1'b1;
`endif

    // Tile abandons the cycle mid-access.
    idle(1);
    s_wb_adr_i = 28'h800; s_wb_we_i = 1'b0; s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1;
    @(negedge clk);
    check("drop_acc", 64'(m_wb_cyc_o), 64'd1);
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    check("drop_still_acc", 64'(m_wb_cyc_o), 64'd1);
    m_wb_ack_i = 1'b1; m_wb_dat_i = 32'hA5A50001;
    @(negedge clk);
    m_wb_ack_i = 1'b0;
    check("drop_resp", 64'({m_wb_cyc_o, term_now()}), 64'd0);
    after_resp = 1'b1;

    // Reset during ACCESS, with a late ack.
    idle(1);
    s_wb_adr_i = 28'h900; s_wb_we_i = 1'b0; s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1;
    @(negedge clk);
    check("rst_mid_acc", 64'(m_wb_cyc_o), 64'd1);
    rst = 1'b1;
    m_wb_ack_i = 1'b1; m_wb_dat_i = 32'hFFFF0000;
    @(negedge clk);
    check("rst_mid_m", 64'({m_wb_cyc_o, m_wb_stb_o, m_wb_adr_o}), 64'd0);
    check("rst_mid_s", 64'({term_now(), timeout_o, s_wb_dat_o}), 64'd0);
    rst = 1'b0;
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0;
    @(negedge clk);
    m_wb_ack_i = 1'b0;
    check("rst_late_ack", 64'({m_wb_cyc_o, term_now()}), 64'd0);
    after_resp = 1'b0;
    xfer(28'hA00, 32'h13579BDF, 4'h5, 1'b1, 2, 3'b001, 32'h0, 3'b000, 1'b1);

    // Randomized beats, bursts and idle gaps.
    for (int t = 0; t < 30; t++) begin
      r_adr   = AW'($urandom);
      r_kinds = 3'($urandom_range(1, 7));
      r_last  = ($urandom_range(0, 2) == 0);
      xfer(r_adr, $urandom, SW'($urandom), 1'($urandom), $urandom_range(0, 4),
           r_kinds, $urandom, r_last ? 3'b111 : 3'b010, r_last);
      if (r_last && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_ext_guard.md
# wb_ext_guard

Registered Wishbone B3 bridge between a compute tile's external memory master port (`wb_ext_*`) and the Wishbone-to-AXI DDR converter. It cuts the combinational path between tile and DDR converter and decomposes tile bursts into classic single-beat cycles. It also protects the tile from a hung memory path: a downstream access that never answers is terminated with a bus error after a bounded number of cycles.

## Interface
Parameters:
- `ADDR_WIDTH`, 28: Wishbone address width.
- `DATA_WIDTH`, 32: Wishbone data width; must be a multiple of 8.
- `TIMEOUT`, 1024: maximum cycles a downstream access may stay in ACCESS; must be ≥ 1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `s_wb_adr_i` in ADDR_WIDTH: upstream address.
- `s_wb_dat_i` in DATA_WIDTH: upstream write data.
- `s_wb_sel_i` in DATA_WIDTH/8: upstream byte select.
- `s_wb_we_i` in 1: upstream write enable.
- `s_wb_cyc_i`, `s_wb_stb_i` in 1 each: upstream cycle and strobe.
- `s_wb_cti_i` in 3, `s_wb_bte_i` in 2: upstream burst tags. Accepted; used only to define burst beats.
- `s_wb_ack_o`, `s_wb_err_o`, `s_wb_rty_o` out 1 each: upstream termination.
- `s_wb_dat_o` out DATA_WIDTH: upstream read data.
- `m_wb_adr_o`, `m_wb_dat_o`, `m_wb_sel_o`, `m_wb_we_o`, `m_wb_cyc_o`, `m_wb_stb_o` out: downstream request. Widths match the corresponding `s_wb_*` signals.
- `m_wb_cti_o` out 3, `m_wb_bte_o` out 2: constant 3'b000 and 2'b00.
- `m_wb_ack_i`, `m_wb_err_i`, `m_wb_rty_i` in 1 each: downstream termination.
- `m_wb_dat_i` in DATA_WIDTH: downstream read data.
- `timeout_o` out 1: one-cycle pulse when an access is aborted by the watchdog.

## Operation
- FSM with three states: IDLE, ACCESS, RESPOND.
- **IDLE**
  - When `s_wb_cyc_i & s_wb_stb_i`: register adr/dat/sel/we, clear the watchdog counter, go to ACCESS.
- **ACCESS**
  - `m_wb_cyc_o = m_wb_stb_o = 1`; request fields are driven from the registers.
  - On `m_wb_err_i | m_wb_rty_i | m_wb_ack_i`:
    - register the response kind, priority err > rty > ack;
    - register `m_wb_dat_i`;
    - go to RESPOND.
  - Otherwise the counter increments.
- **RESPOND**
  - Exactly one of `s_wb_ack_o`/`s_wb_err_o`/`s_wb_rty_o` is high, gated by `s_wb_cyc_i`.
  - `s_wb_dat_o` holds the registered data.
  - Next state: IDLE.
- Bursts (cti 010) and end-of-burst (cti 111):
  - each beat is an independent IDLE→ACCESS→RESPOND pass;
  - downstream sees classic cycles, with `m_wb_cyc_o` low for at least one cycle between beats.
- IDLE does not re-capture the beat just acknowledged: the RESPOND→IDLE transition consumes the cycle in which the upstream updates its request.
- Upstream drops `s_wb_cyc_i` during ACCESS (protocol violation): the downstream access still completes, and its response is discarded by the cyc gating.
- `s_wb_dat_o` is 0 unless the last response was a read ack.
- Reset values:
  - all `m_wb_*` request outputs 0;
  - all `s_wb_*` termination outputs 0;
  - `s_wb_dat_o` 0, `timeout_o` 0, state IDLE, counter 0.
- Reset asserted mid-operation:
  - the next cycle is IDLE with `m_wb_cyc_o = 0`;
  - a late downstream ack is ignored.

## Timing
- Upstream request sampled at edge N → `m_wb_stb_o` high in cycle N+1.
- Downstream ack in cycle K → upstream ack in cycle K+1.
- Minimum beat cost is 3 cycles (IDLE, ACCESS, RESPOND), for a zero-wait downstream.
- Response outputs are registered. Request outputs are registered.
- Watchdog:
  - counter width `$clog2(TIMEOUT+1)`;
  - if the count equals TIMEOUT-1 in ACCESS with no response, the next state is RESPOND with err;
  - `timeout_o` pulses in that RESPOND cycle;
  - `m_wb_cyc_o` drops at the same edge.
- A response arriving in the same cycle the count reaches TIMEOUT-1 is honoured as a normal response (response wins, no timeout).

## Configuration
- `WB_EXT_GUARD_TIMEOUT_EN` defined: watchdog as described.
- `WB_EXT_GUARD_TIMEOUT_EN` undefined:
  - counter is removed;
  - ACCESS waits indefinitely;
  - `timeout_o` is tied to 0.

## Test plan
- Single write, adr 0x0000100, dat 0xCAFEF00D, sel 0xF; zero-wait downstream ack → `m_wb_stb_o` 1 cycle after request; `s_wb_ack_o` 2 cycles after request; downstream sees identical adr/dat/sel/we=1.
- Single read, downstream returns 0x12345678 after 5 wait cycles → `s_wb_ack_o` one cycle after `m_wb_ack_i`, with `s_wb_dat_o` = 0x12345678.
- 4-beat incrementing burst (cti 010,010,010,111) from 0x40 → four classic downstream cycles at 0x40/0x44/0x48/0x4C; `m_wb_cti_o` = 000 throughout; `m_wb_cyc_o` low between beats; four upstream acks.
- Downstream never responds, TIMEOUT=16 → `s_wb_err_o` and `timeout_o` high exactly 17 cycles after the request edge; `m_wb_cyc_o` low afterwards; a late `m_wb_ack_i` causes no upstream activity.
- Downstream asserts err and ack together → upstream sees err only; same test with rty+ack → rty only.
- `rst` asserted during ACCESS → next cycle `m_wb_cyc_o` = 0, all outputs 0; next request is served normally.
